uart_tx_frame_gen: RTL and testbench

- Parametrised UART transmit frame engine; successor to the TX parity calculator.
- Captures a parallel word on a valid strobe and serialises it as start, data LSB-first, optional parity, and 1 or 2 stop bits, one bit per CLK.
- CLK is the TX baud-rate clock from the clock divider; sits between the TX FIFO/system controller and the UART pin.
- Parity generation is extended to four runtime-selectable modes and is registered, not combinational.

---
 rtl/uart_tx_pkg.sv | 21 ++
 rtl/parity_bit_gen.sv | 24 ++
 rtl/uart_tx_frame_gen.sv | 140 ++++++++++++++
 tb/tb_uart_tx_frame_gen.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit frame engine and its parity helper.
// FSM encodings, parity-mode codes and the supported data-width range.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic [1:0] PAR_EVEN  = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_SPACE = 2'b10;
    localparam logic [1:0] PAR_MARK  = 2'b11;

    localparam int DATA_WIDTH_MIN = 5;
    localparam int DATA_WIDTH_MAX = 9;

endpackage

// File: rtl/parity_bit_gen.sv
// Combinational parity for a data word in one of four modes (even/odd/space/mark).
// Zero latency, no flow control; the caller registers the result.
module parity_bit_gen
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [1:0]            mode_i,
    output logic                  parity_o
);

    always_comb begin
        parity_o = 1'b0;
        case (mode_i)
            PAR_EVEN:  parity_o = ^data_i;
            PAR_ODD:   parity_o = ~^data_i;
            PAR_SPACE: parity_o = 1'b0;
            PAR_MARK:  parity_o = 1'b1;
            default:   parity_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/uart_tx_frame_gen.sv
// UART TX framer: start, DATA_WIDTH bits LSB-first, optional parity, 1-2 stop bits, one bit per CLK.
// Start bit appears the cycle after acceptance; Data_Valid is dropped (not queued) while Busy.
module uart_tx_frame_gen
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter bit IDLE_LEVEL = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  par_EN,
    input  logic [1:0]            PAR_TYP,
    input  logic                  STOP_2,
    output logic                  TX_OUT,
    output logic                  Busy,
    output logic                  PARITY_BIT
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    tx_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_en_q, par_en_d;
    logic                  stop2_q, stop2_d;
    logic                  par_q, par_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  par_calc;

    parity_bit_gen #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
        .data_i   (P_DATA),
        .mode_i   (PAR_TYP),
        .parity_o (par_calc)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            stop2_q    <= 1'b0;
            par_q      <= 1'b0;
            stop_cnt_q <= 1'b0;
            tx_q       <= IDLE_LEVEL;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            stop2_q    <= stop2_d;
            par_q      <= par_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        stop2_d    = stop2_q;
        par_d      = par_q;
        stop_cnt_d = stop_cnt_q;
        case (state_q)
            IDLE: begin
                if (Data_Valid) begin
                    state_d    = START;
                    shift_d    = P_DATA;
                    par_en_d   = par_EN;
                    stop2_d    = STOP_2;
                    par_d      = par_calc;
                    cnt_d      = '0;
                    stop_cnt_d = 1'b0;
                end
            end
            START: state_d = DATA;
            DATA: begin
                shift_d = shift_q >> 1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = par_en_q ? PARITY : STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PARITY: state_d = STOP;
            STOP: begin
                if (stop2_q && !stop_cnt_q) begin
                    stop_cnt_d = 1'b1;
                end else begin
                    stop_cnt_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so that every pin comes straight off a flop.
    always_comb begin
        tx_d   = IDLE_LEVEL;
        busy_d = 1'b0;
        case (state_d)
            START: begin
                tx_d   = ~IDLE_LEVEL;
                busy_d = 1'b1;
            end
            DATA: begin
                tx_d   = shift_d[0];
                busy_d = 1'b1;
            end
            PARITY: begin
                tx_d   = par_d;
                busy_d = 1'b1;
            end
            STOP: begin
                tx_d   = IDLE_LEVEL;
                busy_d = 1'b1;
            end
            default: begin
                tx_d   = IDLE_LEVEL;
                busy_d = 1'b0;
            end
        endcase
    end

    assign TX_OUT     = tx_q;
    assign Busy       = busy_q;
    assign PARITY_BIT = par_q;

endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// Drives three framer builds (8-bit, 5-bit, 9-bit with low idle level) against a frame-level reference.
module tb_uart_tx_frame_gen;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [8:0] pd   [3];
    logic       dv   [3];
    logic       pen  [3];
    logic [1:0] typ  [3];
    logic       s2   [3];
    logic       tx   [3];
    logic       busy [3];
    logic       pb   [3];

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    uart_tx_frame_gen #(.DATA_WIDTH(8), .IDLE_LEVEL(1'b1)) dut8 (
        .CLK(CLK), .RST(RST), .P_DATA(pd[0][7:0]), .Data_Valid(dv[0]), .par_EN(pen[0]),
        .PAR_TYP(typ[0]), .STOP_2(s2[0]), .TX_OUT(tx[0]), .Busy(busy[0]), .PARITY_BIT(pb[0]));

    uart_tx_frame_gen #(.DATA_WIDTH(5), .IDLE_LEVEL(1'b1)) dut5 (
        .CLK(CLK), .RST(RST), .P_DATA(pd[1][4:0]), .Data_Valid(dv[1]), .par_EN(pen[1]),
        .PAR_TYP(typ[1]), .STOP_2(s2[1]), .TX_OUT(tx[1]), .Busy(busy[1]), .PARITY_BIT(pb[1]));

    uart_tx_frame_gen #(.DATA_WIDTH(9), .IDLE_LEVEL(1'b0)) dut9 (
        .CLK(CLK), .RST(RST), .P_DATA(pd[2]), .Data_Valid(dv[2]), .par_EN(pen[2]),
        .PAR_TYP(typ[2]), .STOP_2(s2[2]), .TX_OUT(tx[2]), .Busy(busy[2]), .PARITY_BIT(pb[2]));

    function automatic int wid(int i);
        return (i == 0) ? 8 : ((i == 1) ? 5 : 9);
    endfunction

    function automatic bit idl(int i);
        return (i != 2);
    endfunction

    function automatic bit ref_par(logic [8:0] d, int w, logic [1:0] ty);
        logic [8:0] mask;
        int ones;
        mask = (9'h1 << w) - 9'h1;
        ones = $countones(d & mask);
        case (ty)
            2'b00:   return (ones % 2) == 1;
            2'b01:   return (ones % 2) == 0;
            2'b10:   return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(int i);
        int n = 0;
        while (busy[i] !== 1'b0 && n < 64) begin
            @(negedge CLK);
            n++;
        end
        chk("wait_idle", {15'b0, busy[i]}, 16'h0);
    endtask

    // One frame: build the expected line sequence from the framing rules, then compare cycle by cycle.
    task automatic send(int i, logic [8:0] d, bit pe, logic [1:0] ty, bit st2, bit disturb, bit late_dv);
        bit e [16];
        int len;
        int w;
        bit p;
        bit il;
        w  = wid(i);
        il = idl(i);
        p  = ref_par(d, w, ty);
        e[0] = ~il;
        for (int b = 0; b < w; b++) e[1+b] = d[b];
        len = 1 + w;
        if (pe) begin e[len] = p; len++; end
        e[len] = il; len++;
        if (st2) begin e[len] = il; len++; end

        wait_idle(i);
        pd[i] = d; pen[i] = pe; typ[i] = ty; s2[i] = st2; dv[i] = 1'b1;
        @(posedge CLK);
        #1 dv[i] = 1'b0;
        for (int k = 0; k < len; k++) begin
            @(negedge CLK);
            chk($sformatf("tx_bit%0d_w%0d", k, w), {15'b0, tx[i]}, {15'b0, e[k]});
            chk("busy_in_frame", {15'b0, busy[i]}, 16'h1);
            if (k == 0) chk("parity_bit", {15'b0, pb[i]}, {15'b0, p});
            if (disturb && k == 1) begin
                dv[i] = 1'b1; pd[i] = 9'h1FF; pen[i] = ~pe; typ[i] = ty ^ 2'b11; s2[i] = ~st2;
            end
            if (disturb && k == 3) dv[i] = 1'b0;
            if (late_dv && k == len - 1) dv[i] = 1'b1;
        end
        @(negedge CLK);
        dv[i] = 1'b0;
        chk("idle_tx", {15'b0, tx[i]}, {15'b0, il});
        chk("idle_busy", {15'b0, busy[i]}, 16'h0);
        chk("parity_hold", {15'b0, pb[i]}, {15'b0, p});
        if (late_dv) begin
            @(negedge CLK);
            chk("late_dv_dropped", {15'b0, busy[i]}, 16'h0);
            chk("late_dv_tx", {15'b0, tx[i]}, {15'b0, il});
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            pd[i] = '0; dv[i] = 1'b0; pen[i] = 1'b0; typ[i] = 2'b00; s2[i] = 1'b0;
        end
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        for (int i = 0; i < 3; i++) begin
            chk("rst_tx", {15'b0, tx[i]}, {15'b0, idl(i)});
            chk("rst_busy", {15'b0, busy[i]}, 16'h0);
            chk("rst_pb", {15'b0, pb[i]}, 16'h0);
        end
        RST = 1'b0;
        @(negedge CLK);

        // Abort in the middle of data bit 3, then a clean frame must follow.
        pd[0] = 9'h0A5; pen[0] = 1'b1; typ[0] = 2'b11; s2[0] = 1'b1; dv[0] = 1'b1;
        @(posedge CLK);
        #1 dv[0] = 1'b0;
        repeat (5) @(negedge CLK);
        chk("pre_abort_bit3", {15'b0, tx[0]}, 16'h0);
        chk("pre_abort_busy", {15'b0, busy[0]}, 16'h1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("abort_tx", {15'b0, tx[0]}, 16'h1);
        chk("abort_busy", {15'b0, busy[0]}, 16'h0);
        chk("abort_pb", {15'b0, pb[0]}, 16'h0);
        @(negedge CLK);
        chk("abort_no_stop", {15'b0, tx[0]}, 16'h1);

        send(0, 9'h0A5, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        send(0, 9'h007, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
        send(0, 9'h007, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        send(0, 9'h000, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
        send(0, 9'h000, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        send(0, 9'h03C, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        send(0, 9'h05A, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1);
        send(1, 9'h013, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        send(1, 9'h00E, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0);
        send(2, 9'h1C3, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0);
        send(2, 9'h101, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1);

        for (int n = 0; n < 24; n++) begin
            send($urandom_range(0, 2), 9'($urandom), 1'($urandom), 2'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
